// File: rtl/gt_4_bist_ctrl_if.sv
// Bus between the greater-than comparator BIST sequencer and the rest of the board:
// operands out, comparator result in, sweep status and results out.
interface gt_4_bist_ctrl_if #(
    parameter int W = 4
);
    logic             start;
    logic [W-1:0]     a_out;
    logic [W-1:0]     b_out;
    logic             agtb_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2*W:0]     err_count;
    logic             first_fail_valid;
    logic [W-1:0]     first_fail_a;
    logic [W-1:0]     first_fail_b;

    // Board side: issues start, closes the loop through the comparator, reads results.
    modport master (
        output start,
        output agtb_in,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_valid,
        input  first_fail_a,
        input  first_fail_b
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  agtb_in,
        output a_out,
        output b_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_valid,
        output first_fail_a,
        output first_fail_b
    );
endinterface

// File: rtl/gt_4_bist_ctrl.sv
// Exhaustive BIST sequencer for a W-bit a>b comparator: sweeps every (a,b) pair,
// holds each for SETTLE_CYCLES, then checks agtb against a golden a>b.
module gt_4_bist_ctrl #(
    parameter int W             = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    gt_4_bist_ctrl_if.slave       bus
);
    localparam int IW = 2 * W;
    localparam int EW = 2 * W + 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic [EW-1:0]   r_err;
    logic            r_ffv;
    logic [W-1:0]    r_ffa;
    logic [W-1:0]    r_ffb;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    logic            w_golden;
    logic            w_mismatch;
    logic [EW-1:0]   w_err_next;

    // Golden reference and the error count this CHECK cycle would produce.
    always_comb begin
        w_golden   = (r_idx[W-1:0] > r_idx[IW-1:W]);
        w_mismatch = (bus.agtb_in != w_golden);
        w_err_next = r_err + {{(EW-1){1'b0}}, w_mismatch};
    end

    // Sweep FSM; every result output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_ffv   <= 1'b0;
            r_ffa   <= '0;
            r_ffb   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_SETTLE;
                        r_idx   <= '0;
                        r_cnt   <= CNT_LOAD;
                        r_err   <= '0;
                        r_ffv   <= 1'b0;
                        r_ffa   <= '0;
                        r_ffb   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_next;
                    // Only the first mismatch of the sweep is latched for diagnosis.
                    if (w_mismatch && !r_ffv) begin
                        r_ffv <= 1'b1;
                        r_ffa <= r_idx[W-1:0];
                        r_ffb <= r_idx[IW-1:W];
                    end else begin
                        r_ffv <= r_ffv;
                    end
                    if (r_idx == IDX_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_state <= S_SETTLE;
                        r_idx   <= r_idx + IW'(1);
                        r_cnt   <= CNT_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_out            = r_idx[W-1:0];
    assign bus.b_out            = r_idx[IW-1:W];
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.pass             = r_pass;
    assign bus.err_count        = r_err;
    assign bus.first_fail_valid = r_ffv;
    assign bus.first_fail_a     = r_ffa;
    assign bus.first_fail_b     = r_ffb;
endmodule

// File: tb/tb_gt_4_bist_ctrl.sv
// Directed bench for gt_4_bist_ctrl: a table of comparator fault models swept end to end,
// plus hand sequences for reset mid-sweep and start held / re-pulsed.
module tb_gt_4_bist_ctrl;
    localparam int W  = 4;
    localparam int SC = 2;
    localparam int SWEEP_CYCLES = 256 * (SC + 1);

    logic clk;
    logic reset;
    int   mode;
    int   total;
    int   bad;

    gt_4_bist_ctrl_if #(.W(W)) bus ();

    gt_4_bist_ctrl #(.W(W), .SETTLE_CYCLES(SC)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator stand-in: 0 ideal, 1 stuck-0, 2 stuck-1, 3 inverted.
    always_comb begin
        case (mode)
            1:       bus.agtb_in = 1'b0;
            2:       bus.agtb_in = 1'b1;
            3:       bus.agtb_in = !(bus.a_out > bus.b_out);
            default: bus.agtb_in = (bus.a_out > bus.b_out);
        endcase
    end

    typedef struct {
        int          mode;
        logic [8:0]  err;
        logic        ffv;
        logic [3:0]  ffa;
        logic [3:0]  ffb;
        logic        pass;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".a_out"},     32'(bus.a_out), 32'd0);
        chk({tag, ".b_out"},     32'(bus.b_out), 32'd0);
        chk({tag, ".busy"},      32'(bus.busy), 32'd0);
        chk({tag, ".done"},      32'(bus.done), 32'd0);
        chk({tag, ".pass"},      32'(bus.pass), 32'd0);
        chk({tag, ".err_count"}, 32'(bus.err_count), 32'd0);
        chk({tag, ".ffv"},       32'(bus.first_fail_valid), 32'd0);
        chk({tag, ".ffa"},       32'(bus.first_fail_a), 32'd0);
        chk({tag, ".ffb"},       32'(bus.first_fail_b), 32'd0);
    endtask

    // Start a sweep and count cycles until done; hold_start keeps start high throughout.
    task automatic run_sweep(input string tag, input bit hold_start, output int cycles);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) bus.start = 1'b0;
        chk({tag, ".busy_rise"}, 32'(bus.busy), 32'd1);
        chk({tag, ".done_clr"},  32'(bus.done), 32'd0);
        chk({tag, ".err_clr"},   32'(bus.err_count), 32'd0);
        chk({tag, ".ffv_clr"},   32'(bus.first_fail_valid), 32'd0);
        cycles = 0;
        while (cycles < SWEEP_CYCLES + 50) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 2) chk({tag, ".hold_a"}, 32'(bus.a_out), 32'd0);
            if (cycles == 3) chk({tag, ".vec1_a"}, 32'(bus.a_out), 32'd1);
            if (cycles == 48) begin
                chk({tag, ".vec16_a"}, 32'(bus.a_out), 32'd0);
                chk({tag, ".vec16_b"}, 32'(bus.b_out), 32'd1);
            end
            if (bus.done) break;
        end
        bus.start = 1'b0;
        chk({tag, ".done_latency"}, 32'(cycles), 32'(SWEEP_CYCLES));
        chk({tag, ".busy_fall"},    32'(bus.busy), 32'd0);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, ".err_count"}, 32'(bus.err_count), 32'(v.err));
        chk({tag, ".ffv"},       32'(bus.first_fail_valid), 32'(v.ffv));
        chk({tag, ".ffa"},       32'(bus.first_fail_a), 32'(v.ffa));
        chk({tag, ".ffb"},       32'(bus.first_fail_b), 32'(v.ffb));
        chk({tag, ".pass"},      32'(bus.pass), 32'(v.pass));
    endtask

    initial begin
        int cyc;
        total = 0;
        bad   = 0;
        mode  = 0;
        bus.start = 1'b0;
        reset = 1'b1;

        // Expected results hand-derived: 120 pairs have a>b, 136 have a<=b.
        vecs[0] = '{mode: 0, err: 9'd0,   ffv: 1'b0, ffa: 4'd0, ffb: 4'd0, pass: 1'b1};
        vecs[1] = '{mode: 1, err: 9'd120, ffv: 1'b1, ffa: 4'd1, ffb: 4'd0, pass: 1'b0};
        vecs[2] = '{mode: 2, err: 9'd136, ffv: 1'b1, ffa: 4'd0, ffb: 4'd0, pass: 1'b0};
        vecs[3] = '{mode: 3, err: 9'd256, ffv: 1'b1, ffa: 4'd0, ffb: 4'd0, pass: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_no_start.busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            run_sweep($sformatf("tbl%0d", i), 1'b0, cyc);
            check_result($sformatf("tbl%0d", i), vecs[i]);
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.done_held", i), 32'(bus.done), 32'd1);
            check_result($sformatf("tbl%0d.held", i), vecs[i]);
        end

        // Reset at busy cycle 300 discards the partial sweep (stuck-0 errors already counted).
        mode = 1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        chk("midrst.busy_before", 32'(bus.busy), 32'd1);
        chk("midrst.err_before", 32'(bus.err_count != 9'd0), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst.stays_idle", 32'(bus.busy), 32'd0);
        run_sweep("after_rst", 1'b0, cyc);
        check_result("after_rst", vecs[0]);

        // Start held through a failing sweep must not restart it; re-pulse then gives a clean run.
        mode = 1;
        run_sweep("held", 1'b1, cyc);
        check_result("held", vecs[1]);
        mode = 0;
        repeat (2) @(posedge clk);
        run_sweep("repulse", 1'b0, cyc);
        check_result("repulse", vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
